alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, registered successor of the single-cycle ALU, running on the one core clock.
- Executes the 16 data-processing opcodes with a one-cycle registered latency.
- Adds iterative MUL, MLA and UDIV operations that take WIDTH cycles each, using a Start/Busy/Done handshake.
- Sits in the execute stage; the hazard unit stalls the pipeline while Busy=1.

Parameters:
- WIDTH, 32, datapath width in bits; legal range 8..64.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  5  Op[4]=0: ALU op in Op[3:0]; 10000 MUL, 10001 MLA, 10010 UDIV; 10011..11111 reserved.
- Src_A  in  WIDTH  operand A; dividend for UDIV.
- Src_B  in  WIDTH  operand B; divisor for UDIV.
- Src_C  in  WIDTH  accumulate addend, used by MLA only.
- C_in  in  1  carry in for ADC, SBC and RSC.
- Busy  out  1  high while a multi-cycle op is running.
- Done  out  1  one-cycle pulse; Result and ALUFlags are valid in that cycle.
- Result  out  WIDTH  registered result; held until the next Done.
- ALUFlags  out  4  registered {N,Z,C,V}; held until the next Done.

Behaviour:
- Reset: state IDLE, Busy=0, Done=0, Result=0, ALUFlags=0000.
  - Applies from any state; an operation in flight is abandoned with no Done.
- Op[3:0] encoding (arith = A + B' + cin):
  - 0000 AND; 0001 EOR; 1100 ORR; 1101 MOV (B); 1110 BIC (A&~B); 1111 MVN (~B).
  - 0100 ADD: A+B+0.
  - 0101 ADC: A+B+C_in.
  - 0010 SUB: A+~B+1.
  - 0011 RSB: B+~A+1.
  - 0110 SBC: A+~B+C_in.
  - 0111 RSC: B+~A+C_in.
  - 1000 TST: as AND. 1001 TEQ: as EOR. 1010 CMP: as SUB. 1011 CMN: as ADD.
  - TST, TEQ, CMP and CMN still write Result; the consumer ignores it.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result==0).
  - C = carry out of the WIDTH-bit adder for arith ops; 0 for logical ops.
  - V = signed overflow for arith ops: operand signs equal and result sign differs. 0 for logical ops.
  - MUL/MLA/UDIV: N and Z from Result; C=0, V=0.
- Multi-cycle ops; all arithmetic is modulo 2^WIDTH.
  - MUL = low WIDTH bits of A*B.
  - MLA = low WIDTH bits of A*B + Src_C.
  - UDIV = floor(A/B), unsigned.
  - UDIV with B=0: Result=0, ALUFlags=0100, same latency as a normal UDIV.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with Start=1 and a single-cycle op: result computed from the live inputs and registered → DONE. Latency 1 edge; Busy stays 0.
  - IDLE/DONE with Start=1 and a multi-cycle op: operands latched, counter=WIDTH-1 → RUN.
  - RUN: one iteration per edge (shift-add for MUL/MLA, restoring shift-subtract for UDIV). At the edge where counter==0, Result/ALUFlags are written → DONE.
  - Multi-cycle latency is exactly WIDTH edges from the Start edge to Done=1, with Busy=1 during those WIDTH cycles.
  - DONE with Start=0 → IDLE.
  - Done=1 only in DONE; Busy=1 only in RUN.
- Start while Busy=1 is ignored: no queueing, and the running op is unaffected.
- Input changes during RUN have no effect, because the operands are latched.
- Start is accepted in the DONE cycle, so ops can issue back to back.
- Reserved Op with Start=1: treated as a single-cycle op; Result=0, ALUFlags=0100, Done after 1 edge.
- Result/ALUFlags change only on the edge that enters DONE, or on reset.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+0x00000001, Start 1 cycle → Done next cycle, Result 0x80000000, ALUFlags 1001; Busy never 1.
- ADC 0xFFFFFFFF+0x00000000 with C_in=1 → Result 0, ALUFlags 0110. SBC 5,3 with C_in=0 → Result 1, ALUFlags 0010. RSB A=5,B=3 → Result 0xFFFFFFFE, ALUFlags 1000.
- MUL 0x00010000*0x00010000 → Busy high for exactly 32 cycles, Done on the 32nd edge, Result 0, ALUFlags 0100. MLA 3*4+5 → Result 17, ALUFlags 0000.
- UDIV 100/7 → Result 14, ALUFlags 0000. UDIV 0xFFFFFFFF/1 → Result 0xFFFFFFFF, ALUFlags 1000. UDIV 9/0 → Result 0, ALUFlags 0100.
- Start MUL, then assert Start with ADD mid-RUN → ADD ignored and MUL result correct. Start ADD in the MUL's Done cycle → ADD Done exactly one cycle later.
- RESET at RUN cycle 10 → next cycle Busy=0, Done=0, Result=0, ALUFlags=0000, and no Done pulse. Repeat the first, third and fourth scenarios at WIDTH=8: ADD 0x7F+0x01 → 0x80, ALUFlags 1001; MUL latency 8.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered ALU: 16 data-processing ops in one edge; MUL/MLA/UDIV iterate for WIDTH cycles.
// Start is ignored while Busy=1; Result/ALUFlags hold until the next Done pulse.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [4:0]       Op,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [WIDTH-1:0] Src_C,
  input  logic             C_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_MLA  = 5'b10001;
  localparam logic [4:0] OP_UDIV = 5'b10010;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] x, y, sc_res;
  logic             cin, arith;
  logic [WIDTH:0]   sum;
  logic [3:0]       sc_flags;
  logic             is_mc;

  always_comb begin
    x      = Src_A;
    y      = Src_B;
    cin    = 1'b0;
    arith  = 1'b0;
    sc_res = '0;
    case (Op[3:0])
      4'b0000, 4'b1000: sc_res = Src_A & Src_B;
      4'b0001, 4'b1001: sc_res = Src_A ^ Src_B;
      4'b1100:          sc_res = Src_A | Src_B;
      4'b1101:          sc_res = Src_B;
      4'b1110:          sc_res = Src_A & ~Src_B;
      4'b1111:          sc_res = ~Src_B;
      4'b0100, 4'b1011: arith = 1'b1;
      4'b0101: begin arith = 1'b1; cin = C_in; end
      4'b0010, 4'b1010: begin arith = 1'b1; y = ~Src_B; cin = 1'b1; end
      4'b0011: begin arith = 1'b1; x = Src_B; y = ~Src_A; cin = 1'b1; end
      4'b0110: begin arith = 1'b1; y = ~Src_B; cin = C_in; end
      4'b0111: begin arith = 1'b1; x = Src_B; y = ~Src_A; cin = C_in; end
      default: sc_res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) sc_res = sum[WIDTH-1:0];
    // Op[4] here can only be a reserved code: result forced to zero, flags fall out as 0100.
    if (Op[4]) begin
      sc_res = '0;
      arith  = 1'b0;
    end
    sc_flags = {sc_res[WIDTH-1], sc_res == '0, arith & sum[WIDTH],
                arith & (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1])};
  end

  assign is_mc = (Op == OP_MUL) || (Op == OP_MLA) || (Op == OP_UDIV);

  logic [WIDTH-1:0] mul_acc, div_q, div_rem, mc_res;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             ge;

  // MUL/MLA: a_q is the shifting multiplicand, b_q the multiplier consumed LSB-first.
  // UDIV: a_q is the divisor, b_q the dividend shifting out MSB-first while quotient bits shift in.
  always_comb begin
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    rem_sh   = {acc_q, b_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, a_q};
    ge       = ~rem_diff[WIDTH];
    div_rem  = ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_q    = {b_q[WIDTH-2:0], ge};
    mc_res   = is_div_q ? (dz_q ? '0 : div_q) : mul_acc;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_rem;
          b_d   = div_q;
        end else begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mc_res;
          flags_d  = {mc_res[WIDTH-1], mc_res == '0, 2'b00};
        end
      end
      default: begin
        state_d = S_IDLE;
        if (Start) begin
          if (is_mc) begin
            state_d  = S_RUN;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = (Op == OP_UDIV);
            dz_d     = (Src_B == '0);
            a_d      = (Op == OP_UDIV) ? Src_B : Src_A;
            b_d      = (Op == OP_UDIV) ? Src_A : Src_B;
            acc_d    = (Op == OP_MLA) ? Src_C : '0;
          end else begin
            state_d  = S_DONE;
            result_d = sc_res;
            flags_d  = sc_flags;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign Busy     = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Random and directed stimulus for alu_multicycle at WIDTH=32 and WIDTH=8, with a cycle-level
// reference model that compares Busy/Done/Result/ALUFlags on every falling edge.
module tb_alu_multicycle;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst32, st32, ci32, busy32, done32;
  logic [4:0]  op32;
  logic [31:0] a32, b32, c32, res32;
  logic [3:0]  fl32;

  logic        rst8, st8, ci8, busy8, done8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, c8, res8;
  logic [3:0]  fl8;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RESET(rst32), .Start(st32), .Op(op32), .Src_A(a32), .Src_B(b32),
    .Src_C(c32), .C_in(ci32), .Busy(busy32), .Done(done32), .Result(res32), .ALUFlags(fl32));

  alu_multicycle #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET(rst8), .Start(st8), .Op(op8), .Src_A(a8), .Src_B(b8),
    .Src_C(c8), .C_in(ci8), .Busy(busy8), .Done(done8), .Result(res8), .ALUFlags(fl8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [67:0] act, logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bit is_mc(logic [4:0] op);
    return op == 5'h10 || op == 5'h11 || op == 5'h12;
  endfunction

  // Reference: signed/unsigned integer arithmetic, returns {N,Z,C,V, result}.
  function automatic logic [67:0] ref_op(logic [4:0] op, longint unsigned a, longint unsigned b,
                                         longint unsigned c, logic cin, int w);
    longint unsigned mask, u;
    longint sa, sb, s, lim, ci;
    logic carry, ovf, arith;
    mask  = (64'd1 << w) - 64'd1;
    lim   = longint'(64'd1 << (w - 1));
    sa    = ((a >> (w - 1)) != 0) ? longint'(a) - 2 * lim : longint'(a);
    sb    = ((b >> (w - 1)) != 0) ? longint'(b) - 2 * lim : longint'(b);
    ci    = cin ? 1 : 0;
    carry = 1'b0;
    ovf   = 1'b0;
    arith = 1'b1;
    s     = 0;
    u     = 0;
    case (op)
      5'h00, 5'h08: begin u = a & b;  arith = 1'b0; end
      5'h01, 5'h09: begin u = a ^ b;  arith = 1'b0; end
      5'h0C:        begin u = a | b;  arith = 1'b0; end
      5'h0D:        begin u = b;      arith = 1'b0; end
      5'h0E:        begin u = a & ~b; arith = 1'b0; end
      5'h0F:        begin u = ~b;     arith = 1'b0; end
      5'h04, 5'h0B: begin s = sa + sb;            carry = (a + b) > mask; end
      5'h05:        begin s = sa + sb + ci;       carry = (a + b + cin) > mask; end
      5'h02, 5'h0A: begin s = sa - sb;            carry = a >= b; end
      5'h03:        begin s = sb - sa;            carry = b >= a; end
      5'h06:        begin s = sa - sb - (1 - ci); carry = (a + cin) >= (b + 1); end
      5'h07:        begin s = sb - sa - (1 - ci); carry = (b + cin) >= (a + 1); end
      5'h10:        begin u = a * b;              arith = 1'b0; end
      5'h11:        begin u = a * b + c;          arith = 1'b0; end
      5'h12:        begin u = (b == 0) ? 0 : a / b; arith = 1'b0; end
      default:      begin u = 0;                  arith = 1'b0; end
    endcase
    if (arith) begin
      u   = s;
      ovf = (s >= lim) || (s < -lim);
    end
    u = u & mask;
    return {((u >> (w - 1)) & 64'd1) != 0, u == 0, carry, ovf, u};
  endfunction

  // Abstract cycle model: a countdown of remaining busy cycles plus the held outputs.
  int              m_left[2];
  bit              m_valid[2];
  logic            m_done[2];
  longint unsigned m_res[2], m_pend[2];
  logic [3:0]      m_flags[2], m_pendf[2];

  task automatic model_step(int k, int w, logic rst, logic st, logic [4:0] op,
                            longint unsigned a, longint unsigned b, longint unsigned c, logic cin);
    logic [67:0] r;
    if (rst) begin
      m_valid[k] = 1'b1;
      m_left[k]  = 0;
      m_done[k]  = 1'b0;
      m_res[k]   = 0;
      m_flags[k] = 4'b0000;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      m_done[k] = (m_left[k] == 0);
      if (m_left[k] == 0) begin
        m_res[k]   = m_pend[k];
        m_flags[k] = m_pendf[k];
      end
    end else if (st) begin
      r = ref_op(op, a, b, c, cin, w);
      if (is_mc(op)) begin
        m_left[k]  = w;
        m_pend[k]  = r[63:0];
        m_pendf[k] = r[67:64];
        m_done[k]  = 1'b0;
      end else begin
        m_done[k]  = 1'b1;
        m_res[k]   = r[63:0];
        m_flags[k] = r[67:64];
      end
    end else begin
      m_done[k] = 1'b0;
    end
  endtask

  always @(posedge CLK) begin
    model_step(0, 32, rst32, st32, op32, 64'(a32), 64'(b32), 64'(c32), ci32);
    model_step(1, 8,  rst8,  st8,  op8,  64'(a8),  64'(b8),  64'(c8),  ci8);
  end

  always @(negedge CLK) begin
    if (m_valid[0]) begin
      chk("busy32",  68'(busy32), 68'(m_left[0] > 0));
      chk("done32",  68'(done32), 68'(m_done[0]));
      chk("res32",   68'(res32),  68'(m_res[0]));
      chk("flags32", 68'(fl32),   68'(m_flags[0]));
    end
    if (m_valid[1]) begin
      chk("busy8",  68'(busy8), 68'(m_left[1] > 0));
      chk("done8",  68'(done8), 68'(m_done[1]));
      chk("res8",   68'(res8),  68'(m_res[1]));
      chk("flags8", 68'(fl8),   68'(m_flags[1]));
    end
  end

  task automatic drive(int k, logic s, logic [4:0] op, longint unsigned a, longint unsigned b,
                       longint unsigned c, logic cin);
    if (k == 0) begin
      st32 = s; op32 = op; a32 = a[31:0]; b32 = b[31:0]; c32 = c[31:0]; ci32 = cin;
    end else begin
      st8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; ci8 = cin;
    end
  endtask

  task automatic set_start(int k, logic s);
    if (k == 0) st32 = s;
    else        st8  = s;
  endtask

  task automatic issue(int k, logic [4:0] op, longint unsigned a, longint unsigned b,
                       longint unsigned c, logic cin);
    drive(k, 1'b1, op, a, b, c, cin);
    @(negedge CLK);
    set_start(k, 1'b0);
  endtask

  // Scrambles inputs (including stray Start pulses) while busy; returns at the Done cycle.
  task automatic wait_done(int k, output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ((k == 0) ? done32 : done8) begin
        seen = 1'b1;
        break;
      end
      if ((k == 0) ? busy32 : busy8) begin
        busy_n++;
        drive(k, 1'($urandom % 2), 5'($urandom), 64'($urandom), 64'($urandom),
              64'($urandom), 1'($urandom % 2));
      end
      @(negedge CLK);
    end
    set_start(k, 1'b0);
  endtask

  task automatic run_op(int k, logic [4:0] op, longint unsigned a, longint unsigned b,
                        longint unsigned c, logic cin, string name,
                        longint unsigned er, logic [3:0] ef, int eb);
    int bn;
    bit seen;
    issue(k, op, a, b, c, cin);
    wait_done(k, bn, seen);
    chk({name, "_done"},  68'(seen), 68'(1));
    chk({name, "_lat"},   68'(bn),   68'(eb));
    chk({name, "_res"},   (k == 0) ? 68'(res32) : 68'(res8), 68'(er));
    chk({name, "_flags"}, (k == 0) ? 68'(fl32)  : 68'(fl8),  68'(ef));
  endtask

  function automatic logic [4:0] rand_op();
    int r;
    r = int'($urandom % 10);
    if (r < 5)      return 5'($urandom % 16);
    else if (r < 9) return 5'(16 + $urandom % 3);
    else            return 5'(19 + $urandom % 13);
  endfunction

  function automatic longint unsigned rand_val();
    case ($urandom % 6)
      0:       return 0;
      1:       return 64'hFFFF_FFFF;
      2:       return 64'h8000_0000;
      3:       return 64'($urandom % 16);
      default: return 64'($urandom);
    endcase
  endfunction

  task automatic random_ops(int k, int w, int n);
    logic [4:0] op;
    int bn;
    bit seen;
    for (int i = 0; i < n; i++) begin
      op = rand_op();
      issue(k, op, rand_val(), rand_val(), rand_val(), 1'($urandom % 2));
      wait_done(k, bn, seen);
      chk("rand_done", 68'(seen), 68'(1));
      chk("rand_lat",  68'(bn),   68'(is_mc(op) ? w : 0));
      if ($urandom % 3 == 0) @(negedge CLK);
    end
  endtask

  initial begin
    int nd, bn;
    bit seen;
    rst32 = 1'b1;
    rst8  = 1'b1;
    drive(0, 1'b0, 5'h00, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 5'h00, 0, 0, 0, 1'b0);

    chk("pin_add",  ref_op(5'h04, 64'h7FFF_FFFF, 1, 0, 1'b0, 32), {4'b1001, 64'h8000_0000});
    chk("pin_sbc8", ref_op(5'h06, 5, 3, 0, 1'b0, 8),              {4'b0010, 64'd1});
    chk("pin_mla",  ref_op(5'h11, 3, 4, 5, 1'b0, 32),             {4'b0000, 64'd17});
    chk("pin_rsc",  ref_op(5'h07, 3, 5, 0, 1'b0, 32),             {4'b0010, 64'd1});

    repeat (2) @(negedge CLK);
    chk("reset_busy",  68'(busy32), 68'(0));
    chk("reset_done",  68'(done32), 68'(0));
    chk("reset_res",   68'(res32),  68'(0));
    chk("reset_flags", 68'(fl32),   68'(0));
    rst32 = 1'b0;
    rst8  = 1'b0;
    @(negedge CLK);

    run_op(0, 5'h04, 64'h7FFF_FFFF, 1, 0, 1'b0, "add_ovf", 64'h8000_0000, 4'b1001, 0);
    run_op(0, 5'h05, 64'hFFFF_FFFF, 0, 0, 1'b1, "adc", 0, 4'b0110, 0);
    run_op(0, 5'h06, 5, 3, 0, 1'b0, "sbc", 1, 4'b0010, 0);
    run_op(0, 5'h03, 5, 3, 0, 1'b0, "rsb", 64'hFFFF_FFFE, 4'b1000, 0);
    run_op(0, 5'h10, 64'h0001_0000, 64'h0001_0000, 0, 1'b0, "mul", 0, 4'b0100, 32);
    run_op(0, 5'h11, 3, 4, 5, 1'b0, "mla", 17, 4'b0000, 32);
    run_op(0, 5'h12, 100, 7, 0, 1'b0, "udiv", 14, 4'b0000, 32);
    run_op(0, 5'h12, 64'hFFFF_FFFF, 1, 0, 1'b0, "udiv_max", 64'hFFFF_FFFF, 4'b1000, 32);
    run_op(0, 5'h12, 9, 0, 0, 1'b0, "udiv_zero", 0, 4'b0100, 32);
    run_op(0, 5'h15, 7, 9, 0, 1'b0, "reserved", 0, 4'b0100, 0);

    // ADD requested mid-run must be dropped; then ADD issued in the MUL's Done cycle.
    issue(0, 5'h10, 1234, 5678, 0, 1'b0);
    repeat (5) @(negedge CLK);
    drive(0, 1'b1, 5'h04, 1, 2, 0, 1'b0);
    @(negedge CLK);
    set_start(0, 1'b0);
    wait_done(0, bn, seen);
    chk("mid_mul_done", 68'(seen),  68'(1));
    chk("mid_mul_lat",  68'(bn),    68'(26));
    chk("mid_mul_res",  68'(res32), 68'(7006652));
    run_op(0, 5'h04, 10, 20, 0, 1'b0, "b2b_add", 30, 4'b0000, 0);

    // Reset in RUN cycle 10 abandons the multiply.
    issue(0, 5'h10, 12345, 678, 0, 1'b0);
    repeat (9) @(negedge CLK);
    chk("rst_pre_busy", 68'(busy32), 68'(1));
    rst32 = 1'b1;
    @(negedge CLK);
    rst32 = 1'b0;
    chk("rst_busy",  68'(busy32), 68'(0));
    chk("rst_done",  68'(done32), 68'(0));
    chk("rst_res",   68'(res32),  68'(0));
    chk("rst_flags", 68'(fl32),   68'(0));
    nd = 0;
    repeat (40) begin
      @(negedge CLK);
      if (done32) nd++;
    end
    chk("rst_no_done", 68'(nd), 68'(0));

    random_ops(0, 32, 150);

    run_op(1, 5'h04, 8'h7F, 8'h01, 0, 1'b0, "add8", 8'h80, 4'b1001, 0);
    run_op(1, 5'h10, 8'h10, 8'h10, 0, 1'b0, "mul8", 0, 4'b0100, 8);
    run_op(1, 5'h10, 13, 11, 0, 1'b0, "mul8b", 8'h8F, 4'b1000, 8);
    run_op(1, 5'h12, 100, 7, 0, 1'b0, "udiv8", 14, 4'b0000, 8);
    random_ops(1, 8, 120);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
